// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load extraction, misalign detection,
// register-file write port, same-cycle ID bypass and a retired-instruction counter.
module wb_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_we,
  input  logic [4:0]       mem_wa,
  input  logic [DW-1:0]    mem_alu_res,
  input  logic             mem_is_load,
  input  logic [2:0]       mem_ld_type,
  input  logic [DW-1:0]    mem_ld_word,
  input  logic [4:0]       id_ra1,
  input  logic [4:0]       id_ra2,
  output logic             we,
  output logic [4:0]       wa,
  output logic [DW-1:0]    wd,
  output logic             wb_valid,
  output logic             byp1_hit,
  output logic             byp2_hit,
  output logic             ld_misalign,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LBU = 3'b001,
    LD_LH  = 3'b010,
    LD_LHU = 3'b011,
    LD_LW  = 3'b100
  } ld_type_e;

  logic             valid_q;
  logic             we_q;
  logic [4:0]       wa_q;
  logic [DW-1:0]    wd_q, wd_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] retired_q;

  logic [1:0]  addr_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign addr_lo = mem_alu_res[1:0];

  always_comb begin
    ld_byte = mem_ld_word[7:0];
    case (addr_lo)
      2'd0: ld_byte = mem_ld_word[7:0];
      2'd1: ld_byte = mem_ld_word[15:8];
      2'd2: ld_byte = mem_ld_word[23:16];
      2'd3: ld_byte = mem_ld_word[31:24];
      default: ld_byte = mem_ld_word[7:0];
    endcase
    ld_half = addr_lo[1] ? mem_ld_word[31:16] : mem_ld_word[15:0];
  end

  // Extraction happens before the register so wd is driven straight from a flop.
  always_comb begin
    wd_d  = mem_alu_res;
    mis_d = 1'b0;
    if (mem_is_load) begin
      case (ld_type_e'(mem_ld_type))
        LD_LB:  wd_d = {{(DW-8){ld_byte[7]}}, ld_byte};
        LD_LBU: wd_d = {{(DW-8){1'b0}}, ld_byte};
        LD_LH: begin
          wd_d  = {{(DW-16){ld_half[15]}}, ld_half};
          mis_d = addr_lo[0];
        end
        LD_LHU: begin
          wd_d  = {{(DW-16){1'b0}}, ld_half};
          mis_d = addr_lo[0];
        end
        LD_LW: begin
          wd_d  = mem_ld_word;
          mis_d = |addr_lo;
        end
        default: begin
          wd_d  = mem_ld_word;
          mis_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      mis_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
        mis_q   <= 1'b0;
      end else if (!stall) begin
        valid_q <= mem_valid;
        we_q    <= mem_we;
        wa_q    <= mem_wa;
        wd_q    <= wd_d;
        mis_q   <= mis_d;
      end
      // The slot retires as it leaves WB, so a stalled edge never counts.
      if (!stall && valid_q && !mis_q)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign wb_valid    = valid_q;
  assign ld_misalign = valid_q & mis_q;
  assign we          = valid_q & we_q & (|wa_q) & ~mis_q;
  assign wa          = wa_q;
  assign wd          = wd_q;
  assign byp1_hit    = we & (id_ra1 == wa_q);
  assign byp2_hit    = we & (id_ra2 == wa_q);
  assign retired     = retired_q;

endmodule
